// File: rtl/micro_udp_engine_pkg.sv
// Shared types and helpers for the micro UDP engine blocks.
package micro_udp_engine_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } tx_arb_state_t;

    localparam int TX_ARB_MAX_INPUTS = 8;

    // Saturating add of a small per-cycle increment into a 16-bit statistic.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/micro_udp_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, modulo N.
module micro_udp_rr_pick
    import micro_udp_engine_pkg::*;
#(
    parameter int N = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_win,
    output logic             o_any
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = IDX_W'((int'(i_last) + i) % N);
            if (!o_any && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/micro_udp_tx_arbiter.sv
// Packet-granular round-robin arbiter merging N Avalon-ST frame sources onto one TX port.
// Handshake: a beat moves when valid & ready are both high on a clock edge; valid never waits on ready.
module micro_udp_tx_arbiter
    import micro_udp_engine_pkg::*;
#(
    parameter int NR_INPUTS = 2,
    parameter int DATA_W    = 64,
    parameter int EMPTY_W   = $clog2(DATA_W / 8)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NR_INPUTS-1:0]                in_valid,
    output logic [NR_INPUTS-1:0]                in_ready,
    input  logic [NR_INPUTS-1:0][DATA_W-1:0]    in_data,
    input  logic [NR_INPUTS-1:0]                in_sop,
    input  logic [NR_INPUTS-1:0]                in_eop,
    input  logic [NR_INPUTS-1:0][EMPTY_W-1:0]   in_empty,
    output logic                                out_valid,
    output logic                                out_sop,
    output logic                                out_eop,
    input  logic                                out_ready,
    output logic [DATA_W-1:0]                   out_data,
    output logic [EMPTY_W-1:0]                  out_empty,
    output logic [NR_INPUTS-1:0]                grant,
    output logic [31:0]                         pkt_cnt,
    output logic [15:0]                         sop_err_cnt,
    output tx_arb_state_t                       dbg_state
);

    localparam int IDX_W = (NR_INPUTS > 1) ? $clog2(NR_INPUTS) : 1;

    tx_arb_state_t          r_state;
    logic [NR_INPUTS-1:0]   r_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic [IDX_W-1:0]       r_last_grant;
    logic                   r_first;
    logic [31:0]            r_pkt_cnt;
    logic [15:0]            r_sop_err_cnt;

    logic [NR_INPUTS-1:0]   w_req;
    logic [NR_INPUTS-1:0]   w_bad;
    logic [NR_INPUTS-1:0]   w_win;
    logic                   w_any;
    logic [IDX_W-1:0]       w_win_idx;
    logic                   w_xfer;
    logic [3:0]             w_bad_cnt;
    logic [3:0]             w_err_inc;

    assign w_req = in_valid & in_sop;
    assign w_bad = in_valid & ~in_sop;

    micro_udp_rr_pick #(.N(NR_INPUTS)) u_pick (
        .i_req  (w_req),
        .i_last (r_last_grant),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NR_INPUTS; i++) begin
            if (w_win[i]) w_win_idx = IDX_W'(i);
        end
    end

    // The grant is zero outside PASS, so the mux naturally outputs all zeros when idle.
    always_comb begin
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        out_empty = '0;
        for (int i = 0; i < NR_INPUTS; i++) begin
            if (r_grant[i]) begin
                out_valid = in_valid[i];
                out_sop   = in_sop[i];
                out_eop   = in_eop[i];
                out_data  = in_data[i];
                out_empty = in_empty[i];
            end
        end
    end

    assign in_ready = (r_state == IDLE) ? w_bad : (r_grant & {NR_INPUTS{out_ready}});
    assign w_xfer   = out_valid & out_ready;

    always_comb begin
        w_bad_cnt = '0;
        for (int i = 0; i < NR_INPUTS; i++) begin
            w_bad_cnt = w_bad_cnt + {3'd0, w_bad[i]};
        end
    end

    // Idle drops count every headless beat; in PASS only a repeated SOP on the owner counts.
    assign w_err_inc = (r_state == IDLE) ? w_bad_cnt
                     : ((w_xfer && out_sop && !r_first) ? 4'd1 : 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= IDX_W'(NR_INPUTS - 1);
            r_first      <= 1'b0;
            r_pkt_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_win;
                        r_grant_idx <= w_win_idx;
                        r_first     <= 1'b1;
                        r_state     <= PASS;
                    end
                end
                PASS: begin
                    if (w_xfer) begin
                        r_first <= 1'b0;
                        if (out_eop) begin
                            r_last_grant <= r_grant_idx;
                            r_grant      <= '0;
                            r_pkt_cnt    <= r_pkt_cnt + 32'd1;
                            r_state      <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sop_err_cnt <= '0;
        end else begin
            r_sop_err_cnt <= sat_add16(r_sop_err_cnt, w_err_inc);
        end
    end

    assign grant       = r_grant;
    assign pkt_cnt     = r_pkt_cnt;
    assign sop_err_cnt = r_sop_err_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_micro_udp_tx_arbiter.sv
// Directed table-driven bench for the two-source TX arbiter.
module tb_micro_udp_tx_arbiter;
  import micro_udp_engine_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int EW = 3;

  logic               clk;
  logic               reset_n;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N-1:0][DW-1:0] in_data;
  logic [N-1:0]       in_sop;
  logic [N-1:0]       in_eop;
  logic [N-1:0][EW-1:0] in_empty;
  logic               out_valid;
  logic               out_sop;
  logic               out_eop;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [EW-1:0]      out_empty;
  logic [N-1:0]       grant;
  logic [31:0]        pkt_cnt;
  logic [15:0]        sop_err_cnt;
  tx_arb_state_t      dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  micro_udp_tx_arbiter #(.NR_INPUTS(N), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_empty    (in_empty),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_empty   (out_empty),
    .grant       (grant),
    .pkt_cnt     (pkt_cnt),
    .sop_err_cnt (sop_err_cnt),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  val, sop, eop;
    logic [63:0] d0, d1;
    logic [2:0]  e0;
    logic        ordy;
    logic        xov, xsop, xeop;
    logic [63:0] xod;
    logic [2:0]  xoe;
    logic [1:0]  xrdy, xg;
    logic [31:0] xpkt;
    logic [15:0] xerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [1:0] val, logic [1:0] sop, logic [1:0] eop,
                             logic [63:0] d0, logic [63:0] d1, logic [2:0] e0, logic ordy,
                             logic xov, logic xsop, logic xeop, logic [63:0] xod,
                             logic [2:0] xoe, logic [1:0] xrdy, logic [1:0] xg,
                             logic [31:0] xpkt, logic [15:0] xerr);
    vec_t r;
    r.val = val; r.sop = sop; r.eop = eop; r.d0 = d0; r.d1 = d1; r.e0 = e0; r.ordy = ordy;
    r.xov = xov; r.xsop = xsop; r.xeop = xeop; r.xod = xod; r.xoe = xoe;
    r.xrdy = xrdy; r.xg = xg; r.xpkt = xpkt; r.xerr = xerr;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] val, input logic [1:0] sop, input logic [1:0] eop,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [2:0] e0,
                       input logic ordy);
    in_valid    = val;
    in_sop      = sop;
    in_eop      = eop;
    in_data[0]  = d0;
    in_data[1]  = d1;
    in_empty[0] = e0;
    in_empty[1] = '0;
    out_ready   = ordy;
  endtask

  task automatic check_row(input int i, input vec_t r);
    check($sformatf("r%0d.out_valid", i), 64'(out_valid), 64'(r.xov));
    check($sformatf("r%0d.out_sop", i), 64'(out_sop), 64'(r.xsop));
    check($sformatf("r%0d.out_eop", i), 64'(out_eop), 64'(r.xeop));
    check($sformatf("r%0d.out_data", i), out_data, r.xod);
    check($sformatf("r%0d.out_empty", i), 64'(out_empty), 64'(r.xoe));
    check($sformatf("r%0d.in_ready", i), 64'(in_ready), 64'(r.xrdy));
    check($sformatf("r%0d.grant", i), 64'(grant), 64'(r.xg));
    check($sformatf("r%0d.pkt_cnt", i), 64'(pkt_cnt), 64'(r.xpkt));
    check($sformatf("r%0d.sop_err_cnt", i), 64'(sop_err_cnt), 64'(r.xerr));
    check($sformatf("r%0d.state", i), 64'(dbg_state), (r.xg != 2'b00) ? 64'(PASS) : 64'(IDLE));
  endtask

  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_0001, A1 = 64'hA1A1_0000_0000_0002;
  localparam logic [63:0] B0 = 64'hB0B0_0000_0000_0003, B1 = 64'hB1B1_0000_0000_0004;
  localparam logic [63:0] C0 = 64'hC0C0_0000_0000_0005, C1 = 64'hC1C1_0000_0000_0006;
  localparam logic [63:0] C2 = 64'hC2C2_0000_0000_0007, D0 = 64'hD0D0_0000_0000_0008;
  localparam logic [63:0] E0 = 64'hE0E0_0000_0000_0009, F0 = 64'hF0F0_0000_0000_000A;
  localparam logic [63:0] F1 = 64'hF1F1_0000_0000_000B, F2 = 64'hF2F2_0000_0000_000C;
  localparam logic [63:0] G0 = 64'h6060_0000_0000_000D, G1 = 64'h6161_0000_0000_000E;
  localparam logic [63:0] H0 = 64'h7070_0000_0000_000F, J0 = 64'h7171_0000_0000_0010;

  initial begin
    // Both sources SOP together: 0 wins, then 1 (grant 01, 10, 00).
    vecs.push_back(v(2'b11, 2'b11, 2'b00, A0, B0, 0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(v(2'b11, 2'b11, 2'b00, A0, B0, 0, 1,  1, 1, 0, A0, 0, 2'b01, 2'b01, 0, 0));
    vecs.push_back(v(2'b11, 2'b10, 2'b01, A1, B0, 0, 1,  1, 0, 1, A1, 0, 2'b01, 2'b01, 0, 0));
    vecs.push_back(v(2'b10, 2'b10, 2'b00, 0,  B0, 0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(v(2'b10, 2'b10, 2'b00, 0,  B0, 0, 1,  1, 1, 0, B0, 0, 2'b10, 2'b10, 1, 0));
    vecs.push_back(v(2'b10, 2'b00, 2'b10, 0,  B1, 0, 1,  1, 0, 1, B1, 0, 2'b10, 2'b10, 1, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 0,  0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 2, 0));
    // Source 1 three-beat packet under out_ready 1,0,1,0,1; source 0 waits with SOP.
    vecs.push_back(v(2'b10, 2'b10, 2'b00, 0,  C0, 0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 2, 0));
    vecs.push_back(v(2'b10, 2'b10, 2'b00, 0,  C0, 0, 1,  1, 1, 0, C0, 0, 2'b10, 2'b10, 2, 0));
    vecs.push_back(v(2'b11, 2'b01, 2'b00, D0, C1, 0, 0,  1, 0, 0, C1, 0, 2'b00, 2'b10, 2, 0));
    vecs.push_back(v(2'b11, 2'b01, 2'b00, D0, C1, 0, 1,  1, 0, 0, C1, 0, 2'b10, 2'b10, 2, 0));
    vecs.push_back(v(2'b11, 2'b01, 2'b10, D0, C2, 0, 0,  1, 0, 1, C2, 0, 2'b00, 2'b10, 2, 0));
    vecs.push_back(v(2'b11, 2'b01, 2'b10, D0, C2, 0, 1,  1, 0, 1, C2, 0, 2'b10, 2'b10, 2, 0));
    // Single-beat SOP+EOP from source 0 with empty = 5, then back to idle.
    vecs.push_back(v(2'b01, 2'b01, 2'b00, D0, 0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 3, 0));
    vecs.push_back(v(2'b01, 2'b01, 2'b01, D0, 0,  5, 1,  1, 1, 1, D0, 5, 2'b01, 2'b01, 3, 0));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 0,  0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 4, 0));
    // Four headless beats from source 0 in idle are dropped.
    for (int k = 0; k < 4; k++)
      vecs.push_back(v(2'b01, 2'b00, 2'b00, E0, 0, 0, 1,  0, 0, 0, 0, 0, 2'b01, 2'b00, 4, 16'(k)));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 0,  0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 4, 4));
    // Repeated SOP inside a packet is forwarded and counted.
    vecs.push_back(v(2'b01, 2'b01, 2'b00, F0, 0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 4, 4));
    vecs.push_back(v(2'b01, 2'b01, 2'b00, F0, 0,  0, 1,  1, 1, 0, F0, 0, 2'b01, 2'b01, 4, 4));
    vecs.push_back(v(2'b01, 2'b01, 2'b00, F1, 0,  0, 1,  1, 1, 0, F1, 0, 2'b01, 2'b01, 4, 4));
    vecs.push_back(v(2'b01, 2'b00, 2'b01, F2, 0,  0, 1,  1, 0, 1, F2, 0, 2'b01, 2'b01, 4, 5));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 0,  0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 5, 5));
    // Two headless beats in one cycle add two.
    vecs.push_back(v(2'b11, 2'b00, 2'b00, G0, G1, 0, 1,  0, 0, 0, 0,  0, 2'b11, 2'b00, 5, 5));
    vecs.push_back(v(2'b00, 2'b00, 2'b00, 0,  0,  0, 1,  0, 0, 0, 0,  0, 2'b00, 2'b00, 5, 7));

    reset_n = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.out_valid", 64'(out_valid), 0);
    check("reset.grant", 64'(grant), 0);
    check("reset.in_ready", 64'(in_ready), 0);
    check("reset.pkt_cnt", 64'(pkt_cnt), 0);
    check("reset.sop_err_cnt", 64'(sop_err_cnt), 0);
    check("reset.state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].val, vecs[i].sop, vecs[i].eop, vecs[i].d0, vecs[i].d1, vecs[i].e0, vecs[i].ordy);
      #1;
      check_row(i, vecs[i]);
    end

    // Saturation: 70000 headless beats, two per cycle, starting from 7.
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, G0, G1, 0, 1'b1);
    repeat (32763) @(posedge clk);
    #1;
    check("sat.below", 64'(sop_err_cnt), 64'h0000_FFFD);
    @(posedge clk);
    #1;
    check("sat.reach", 64'(sop_err_cnt), 64'h0000_FFFF);
    repeat (2236) @(posedge clk);
    #1;
    check("sat.hold", 64'(sop_err_cnt), 64'h0000_FFFF);
    check("sat.in_ready", 64'(in_ready), 64'h3);
    check("sat.out_valid", 64'(out_valid), 0);
    check("sat.pkt_cnt", 64'(pkt_cnt), 5);

    // Mid-packet reset: last owner was 0, so source 1 wins first.
    @(negedge clk);
    drive(2'b11, 2'b11, 2'b00, H0, J0, 0, 1'b0);
    @(negedge clk);
    #1;
    check("rst.pre_grant", 64'(grant), 64'h2);
    check("rst.pre_data", out_data, J0);
    reset_n = 1'b0;
    #1;
    check("rst.grant", 64'(grant), 0);
    check("rst.out_valid", 64'(out_valid), 0);
    check("rst.out_sop", 64'(out_sop), 0);
    check("rst.out_data", out_data, 0);
    check("rst.in_ready", 64'(in_ready), 0);
    check("rst.pkt_cnt", 64'(pkt_cnt), 0);
    check("rst.sop_err_cnt", 64'(sop_err_cnt), 0);
    check("rst.state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst.grant", 64'(grant), 64'h1);
    check("post_rst.out_data", out_data, H0);
    check("post_rst.out_valid", 64'(out_valid), 1);

    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
